bscan_scan_master: RTL and testbench
====================================

# bscan_scan_master

Fabric-side BSCAN master that drives the `M_BSCAN_*` bundle into a reconfigurable partition's `S_BSCAN_*` slave port. It performs one complete DR scan per request: select, capture, shift DATA_W bits LSB-first, then update. This lets on-chip self-test read and write a slave's user register without a JTAG cable. It sits in the static region beside the debug hub, on the same BSCAN interface the RPs already expose.

## Interface
- DATA_W, 32, scan length in bits; legal 1..64.
- DIV, 4, clk cycles per TCK half-period; legal ≥1.
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request a scan; accepted only when busy=0.
- wr_data  in  DATA_W  value shifted out on tdi; latched when start is accepted.
- busy  out  1  high from the cycle after acceptance until the done cycle.
- done  out  1  one-cycle pulse when the scan completes.
- rd_data  out  DATA_W  bits sampled from tdo; held until the next completed scan.
- M_BSCAN_drck, M_BSCAN_tck  out  1  gated and free-running scan clocks (see Operation).
- M_BSCAN_sel, M_BSCAN_capture, M_BSCAN_shift, M_BSCAN_update  out  1  scan phase strobes.
- M_BSCAN_tdi  out  1  serial data to the slave.
- M_BSCAN_tdo  in  1  serial data from the slave.
- M_BSCAN_tms, M_BSCAN_runtest, M_BSCAN_reset, M_BSCAN_bscanid_en  out  1  driven constant 0.

## Operation
- All outputs are registered. There are no glitches on tck or drck.
- FSM states: IDLE, SELECT, CAPTURE, SHIFT, UPDATE.
  - IDLE→SELECT on accepted start.
  - SELECT→CAPTURE→SHIFT after one TCK period each.
  - SHIFT→UPDATE after DATA_W periods; a bit counter runs 0..DATA_W-1.
  - UPDATE→IDLE after one period.
- TCK period = 2·DIV clk cycles. tck is low for the first DIV cycles of each period and high for the last DIV.
- tck toggles in every non-IDLE state. It is low in IDLE.
- drck equals tck during CAPTURE and SHIFT. It is low otherwise.
- Strobe behaviour:
  - sel is high in SELECT, CAPTURE, SHIFT and UPDATE.
  - capture, shift and update are each high for exactly their own state.
  - Each strobe changes only at a period boundary, while tck is low.
- Data out: in SHIFT period i, tdi = latched wr_data[i] for the whole period. tdi is 0 outside SHIFT.
- Data in: tdo is sampled on the clk edge where tck rises in SHIFT period i, into a shift register at bit i. The first sample is the slave's captured bit 0.
- rd_data updates from the shift register on the done cycle only. A partial scan never changes rd_data.
- start while busy=1 is ignored. wr_data changes while busy=1 have no effect.
- start is accepted in the done cycle and in any IDLE cycle.

## Timing
- Reset values (reset_n=0, immediate): state IDLE; every output 0, including rd_data, busy, done, tck and drck.
- Reset mid-scan aborts the scan:
  - all strobes drop at once;
  - no done pulse is issued;
  - rd_data is cleared.
- start sampled high at edge E0 with busy=0:
  - busy=1 and sel=1 from E0+1;
  - the first tck rise occurs at E0+1+DIV.
- done=1 and busy=0 in cycle E0 + (DATA_W+3)·2·DIV + 1.
- If start is high in the done cycle, the next SELECT begins in the following cycle. There are no idle cycles between scans.
- drck rising edges per scan: exactly DATA_W+1 (1 capture + DATA_W shift).
- tck rising edges per scan: exactly DATA_W+3.

## Test plan
Bench parameters: DATA_W=8, DIV=2. The slave model is a BSCAN user register:
- it captures CAP on the capture rising edge of drck;
- it shifts on drck rising edges while shift=1;
- it loads its update register when update is high.

1. Reset: hold reset_n=0, drive start=1 → all outputs 0, busy stays 0. Release → idle outputs stay 0 until the next start.
2. Single scan, wr_data=0xA5, CAP=0x3C, start at E0 → done at E0+45, rd_data=0x3C, slave update register=0xA5; 9 drck rises and 11 tck rises observed.
3. start pulsed at E0+10 and again at E0+30 with a different wr_data → both ignored; single done at E0+45 with results as in scenario 2.
4. start held high, wr_data 0x01 then 0xFF, CAP 0x80 then 0x7F → dones at E0+45 and E0+89; rd_data 0x80 then 0x7F; slave update register 0x01 then 0xFF.
5. reset_n pulsed low at the 4th SHIFT period → all strobes and tck low at once, no done, rd_data=0. Next scan with CAP=0x55 → rd_data=0x55.
6. DIV=1, DATA_W=1, wr_data=1, CAP=0 → done at E0+9, rd_data=0, slave update register=1; tck period is 2 cycles.

Source files
------------

// File: rtl/bscan_scan_master.sv
// bscan_scan_master
// Drives one complete BSCAN DR scan into a reconfigurable partition's slave
// port for each accepted request. The sequence is select, capture, shift
// DATA_W bits LSB-first, then update. On-chip self-test uses it to read and
// write a slave's user register without a JTAG cable.
//
// Ports:
//   clk, reset_n        system clock, asynchronous active-low reset
//   start, wr_data      scan request and the value to shift out on tdi
//   busy, done, rd_data scan in progress, one-cycle completion pulse,
//                       captured tdo bits (held until the next completed scan)
//   M_BSCAN_*           master side of the BSCAN bundle; tms, runtest, reset
//                       and bscanid_en are tied low
//
// Timing: one TCK period is 2*DIV clk cycles. tck is low for the first DIV
// cycles of a period and high for the last DIV. The strobes and tdi change
// only at period boundaries, so they always move while tck is low.

module bscan_scan_master #(
   parameter int DATA_W = 32,
   parameter int DIV    = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [DATA_W-1:0] wr_data,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] rd_data,
   output logic              M_BSCAN_drck,
   output logic              M_BSCAN_tck,
   output logic              M_BSCAN_sel,
   output logic              M_BSCAN_capture,
   output logic              M_BSCAN_shift,
   output logic              M_BSCAN_update,
   output logic              M_BSCAN_tdi,
   input  logic              M_BSCAN_tdo,
   output logic              M_BSCAN_tms,
   output logic              M_BSCAN_runtest,
   output logic              M_BSCAN_reset,
   output logic              M_BSCAN_bscanid_en
);

   localparam int CW = $clog2(2 * DIV);
   localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CW-1:0] HALF  = CW'(DIV);
   localparam logic [CW-1:0] LAST  = CW'(2 * DIV - 1);
   localparam logic [BW-1:0] BLAST = BW'(DATA_W - 1);

   typedef enum logic [2:0] {IDLE, SELECT, CAPTURE, SHIFT, UPDATE} state_t;

   state_t            state, state_nx;
   logic [CW-1:0]     cyc, cyc_nx;
   logic [BW-1:0]     bit_cnt, bit_nx;
   logic [DATA_W-1:0] wr_latch, shreg;
   logic              period_end, finish, accept;

   assign M_BSCAN_tms        = 1'b0;
   assign M_BSCAN_runtest    = 1'b0;
   assign M_BSCAN_reset      = 1'b0;
   assign M_BSCAN_bscanid_en = 1'b0;

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         cyc     <= '0;
         bit_cnt <= '0;
      end else begin
         state   <= state_nx;
         cyc     <= cyc_nx;
         bit_cnt <= bit_nx;
      end
   end

   // Next-state logic. cyc counts clk cycles inside one TCK period, and every
   // state except IDLE lasts whole periods. A start seen in the last UPDATE
   // cycle is accepted immediately, so the next SELECT follows the done cycle
   // with no idle gap.
   always_comb begin
      state_nx   = state;
      cyc_nx     = cyc;
      bit_nx     = bit_cnt;
      finish     = 1'b0;
      accept     = 1'b0;
      period_end = (cyc == LAST);
      case (state)
         IDLE: begin
            cyc_nx = '0;
            bit_nx = '0;
            if (start) begin
               accept   = 1'b1;
               state_nx = SELECT;
            end
         end
         default: begin
            cyc_nx = period_end ? '0 : cyc + 1'b1;
            if (period_end) begin
               case (state)
                  SELECT:  state_nx = CAPTURE;
                  CAPTURE: state_nx = SHIFT;
                  SHIFT: begin
                     if (bit_cnt == BLAST) state_nx = UPDATE;
                     else                  bit_nx   = bit_cnt + 1'b1;
                  end
                  UPDATE: begin
                     finish = 1'b1;
                     bit_nx = '0;
                     if (start) begin
                        accept   = 1'b1;
                        state_nx = SELECT;
                     end else begin
                        state_nx = IDLE;
                     end
                  end
                  default: state_nx = IDLE;
               endcase
            end
         end
      endcase
   end

   // Datapath and output registers. Each output is computed from the next
   // state, so the pins come straight from flops and cannot glitch. tdo is
   // sampled on the edge where tck rises, which is when cyc moves to HALF.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_latch        <= '0;
         shreg           <= '0;
         rd_data         <= '0;
         busy            <= 1'b0;
         done            <= 1'b0;
         M_BSCAN_tck     <= 1'b0;
         M_BSCAN_drck    <= 1'b0;
         M_BSCAN_sel     <= 1'b0;
         M_BSCAN_capture <= 1'b0;
         M_BSCAN_shift   <= 1'b0;
         M_BSCAN_update  <= 1'b0;
         M_BSCAN_tdi     <= 1'b0;
      end else begin
         if (accept) wr_latch <= wr_data;
         if (state == SHIFT && cyc_nx == HALF) shreg[bit_cnt] <= M_BSCAN_tdo;
         if (finish) rd_data <= shreg;
         done            <= finish;
         busy            <= (state_nx != IDLE);
         M_BSCAN_tck     <= (state_nx != IDLE) && (cyc_nx >= HALF);
         M_BSCAN_drck    <= (state_nx == CAPTURE || state_nx == SHIFT) && (cyc_nx >= HALF);
         M_BSCAN_sel     <= (state_nx != IDLE);
         M_BSCAN_capture <= (state_nx == CAPTURE);
         M_BSCAN_shift   <= (state_nx == SHIFT);
         M_BSCAN_update  <= (state_nx == UPDATE);
         M_BSCAN_tdi     <= (state_nx == SHIFT) ? wr_latch[bit_nx] : 1'b0;
      end
   end

endmodule

// File: tb/tb_bscan_scan_master.sv
// tb_bscan_scan_master
// Bench for bscan_scan_master. Instance "a" uses DATA_W=8, DIV=2 and instance
// "b" uses DATA_W=1, DIV=1. Each instance is connected to a behavioural BSCAN
// user-register slave. The slave captures CAP on the capture drck rise,
// shifts on drck rises while shift is high, and loads its update register
// when update rises. Expected results come from the scan rules: rd_data
// equals CAP, the slave update register equals wr_data, and done comes
// (DATA_W+3)*2*DIV edges after the start edge.

module tb_bscan_scan_master;

   localparam int DW = 8;
   localparam int DV = 2;
   localparam int SCAN_EDGES = (DW + 3) * 2 * DV;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic start = 1'b0;
   logic [DW-1:0] wr_data = '0;
   logic [DW-1:0] rd_data;
   logic busy, done, drck, tck, sel, capture, shift, update, tdi, tdo;
   logic tms, runtest, rst_o, bscanid;

   logic b_start = 1'b0;
   logic [0:0] b_wr = '0;
   logic [0:0] b_rd;
   logic b_busy, b_done, b_drck, b_tck, b_sel, b_capture, b_shift, b_update, b_tdi, b_tdo;
   logic b_tms, b_runtest, b_rst, b_bscanid;

   int total = 0;
   int bad = 0;

   // Free-running 10 ns system clock shared by both instances.
   always #5 clk = ~clk;

   bscan_scan_master #(.DATA_W(DW), .DIV(DV)) dut_a (
      .clk(clk), .reset_n(reset_n), .start(start), .wr_data(wr_data),
      .busy(busy), .done(done), .rd_data(rd_data),
      .M_BSCAN_drck(drck), .M_BSCAN_tck(tck), .M_BSCAN_sel(sel),
      .M_BSCAN_capture(capture), .M_BSCAN_shift(shift), .M_BSCAN_update(update),
      .M_BSCAN_tdi(tdi), .M_BSCAN_tdo(tdo), .M_BSCAN_tms(tms),
      .M_BSCAN_runtest(runtest), .M_BSCAN_reset(rst_o), .M_BSCAN_bscanid_en(bscanid)
   );

   bscan_scan_master #(.DATA_W(1), .DIV(1)) dut_b (
      .clk(clk), .reset_n(reset_n), .start(b_start), .wr_data(b_wr),
      .busy(b_busy), .done(b_done), .rd_data(b_rd),
      .M_BSCAN_drck(b_drck), .M_BSCAN_tck(b_tck), .M_BSCAN_sel(b_sel),
      .M_BSCAN_capture(b_capture), .M_BSCAN_shift(b_shift), .M_BSCAN_update(b_update),
      .M_BSCAN_tdi(b_tdi), .M_BSCAN_tdo(b_tdo), .M_BSCAN_tms(b_tms),
      .M_BSCAN_runtest(b_runtest), .M_BSCAN_reset(b_rst), .M_BSCAN_bscanid_en(b_bscanid)
   );

   // Slave user register for instance a.
   logic [DW-1:0] cap_a = '0;
   logic [DW-1:0] sl_sr = '0;
   logic [DW-1:0] sl_upd = '0;
   assign tdo = sl_sr[0];
   always @(posedge drck) begin
      if (capture)    sl_sr <= cap_a;
      else if (shift) sl_sr <= {tdi, sl_sr[DW-1:1]};
   end
   always @(posedge update) sl_upd <= sl_sr;

   // Slave user register for instance b (a single bit).
   logic b_cap = 1'b0;
   logic b_sr = 1'b0;
   logic b_upd = 1'b0;
   assign b_tdo = b_sr;
   always @(posedge b_drck) begin
      if (b_capture)    b_sr <= b_cap;
      else if (b_shift) b_sr <= b_tdi;
   end
   always @(posedge b_update) b_upd <= b_sr;

   // Watchdog so that a stuck design cannot hang the run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, bad=%0d", bad);
      $fatal(1, "[TB] watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DW+13:0] outs_a();
      return {busy, done, rd_data, drck, tck, sel, capture, shift, update, tdi,
              tms, runtest, rst_o, bscanid};
   endfunction

   // Runs the rest of a scan after the start edge. It returns the offset of
   // the done edge (-1 on timeout), the tck and drck rise counts, the offset
   // of the first tck high, and a count of strobe or drck phase errors.
   // With pulse set it pokes start and a fresh wr_data mid-scan.
   task automatic wait_done(input int limit, input bit pulse, output int t,
                            output int tr, output int dr, output int first_tck,
                            output int perr);
      logic ptck, pdrck;
      logic [3:0] pstb;
      t = -1; tr = 0; dr = 0; first_tck = -1; perr = 0;
      ptck = tck; pdrck = drck; pstb = {sel, capture, shift, update};
      for (int k = 0; k < limit; k++) begin
         if (pulse) begin
            start   = (k == 9 || k == 29);
            wr_data = DW'($urandom);
         end
         tick();
         if (tck && !ptck) tr++;
         if (drck && !pdrck) dr++;
         if (tck && first_tck < 0) first_tck = k + 1;
         if (tck && ({sel, capture, shift, update} != pstb)) perr++;
         if ((capture || shift) ? (drck !== tck) : (drck !== 1'b0)) perr++;
         ptck = tck; pdrck = drck; pstb = {sel, capture, shift, update};
         if (done) begin
            t = k + 1;
            break;
         end
      end
      if (pulse) start = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      start   = 1'b1;
      wr_data = 8'hA5;
      for (int i = 0; i < 4; i++) begin
         tick();
         total++;
         if (outs_a() !== '0) begin
            bad++;
            $display("[TB] FAIL reset_hold: outputs=%h want 0", outs_a());
         end
      end
      start   = 1'b0;
      reset_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         total++;
         if (outs_a() !== '0) begin
            bad++;
            $display("[TB] FAIL reset_idle: outputs=%h want 0", outs_a());
         end
      end
   endtask

   task automatic run_single(input logic [DW-1:0] wr, input logic [DW-1:0] cap, input bit pulse);
      int t, tr, dr, ft, perr;
      wr_data = wr;
      cap_a   = cap;
      start   = 1'b1;
      tick();
      start = 1'b0;
      total++;
      if ({busy, sel, tck} !== 3'b110) begin
         bad++;
         $display("[TB] FAIL start_ack: busy,sel,tck=%b want 110", {busy, sel, tck});
      end
      wait_done(SCAN_EDGES + 20, pulse, t, tr, dr, ft, perr);
      total++;
      if (t != SCAN_EDGES) begin
         bad++;
         $display("[TB] FAIL done_time: cycle E0+%0d want E0+%0d", t + 1, SCAN_EDGES + 1);
      end
      total++;
      if (rd_data !== cap || busy !== 1'b0) begin
         bad++;
         $display("[TB] FAIL rd_data: got %h busy %b want %h busy 0", rd_data, busy, cap);
      end
      total++;
      if (sl_upd !== wr) begin
         bad++;
         $display("[TB] FAIL slave_update: got %h want %h", sl_upd, wr);
      end
      total++;
      if (tr != DW + 3 || dr != DW + 1) begin
         bad++;
         $display("[TB] FAIL edge_count: tck %0d drck %0d want %0d %0d", tr, dr, DW + 3, DW + 1);
      end
      total++;
      if (ft != DV || perr != 0) begin
         bad++;
         $display("[TB] FAIL tck_phase: first tck E0+%0d phase errors %0d want E0+%0d 0",
                  ft + 1, perr, DV + 1);
      end
   endtask

   task automatic test_single();
      run_single(8'hA5, 8'h3C, 1'b0);
      for (int i = 0; i < 3; i++) run_single(DW'($urandom), DW'($urandom), 1'b0);
   endtask

   task automatic test_ignore_busy();
      int extra;
      run_single(8'hA5, 8'h3C, 1'b1);
      extra = 0;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (done || busy) extra++;
      end
      total++;
      if (extra != 0) begin
         bad++;
         $display("[TB] FAIL ignore_busy: %0d busy/done cycles after scan want 0", extra);
      end
   endtask

   task automatic test_back_to_back();
      int t1, t2, tr, dr, ft, perr;
      logic [DW-1:0] rd1, upd1;
      wr_data = 8'h01;
      cap_a   = 8'h80;
      start   = 1'b1;
      tick();
      wr_data = 8'hFF;
      wait_done(SCAN_EDGES + 20, 1'b0, t1, tr, dr, ft, perr);
      rd1   = rd_data;
      upd1  = sl_upd;
      start = 1'b0;
      cap_a = 8'h7F;
      wait_done(SCAN_EDGES + 20, 1'b0, t2, tr, dr, ft, perr);
      total++;
      if (t1 != SCAN_EDGES || t2 != SCAN_EDGES) begin
         bad++;
         $display("[TB] FAIL b2b_time: dones at E0+%0d E0+%0d want E0+%0d E0+%0d",
                  t1 + 1, t1 + t2 + 1, SCAN_EDGES + 1, 2 * SCAN_EDGES + 1);
      end
      total++;
      if (rd1 !== 8'h80 || upd1 !== 8'h01) begin
         bad++;
         $display("[TB] FAIL b2b_first: rd %h upd %h want 80 01", rd1, upd1);
      end
      total++;
      if (rd_data !== 8'h7F || sl_upd !== 8'hFF) begin
         bad++;
         $display("[TB] FAIL b2b_second: rd %h upd %h want 7f ff", rd_data, sl_upd);
      end
   endtask

   task automatic test_reset_midscan();
      int guard, dones;
      logic [DW-1:0] cap;
      cap     = DW'($urandom_range(1, 255));
      wr_data = DW'($urandom);
      cap_a   = cap;
      start   = 1'b1;
      tick();
      start = 1'b0;
      guard = 0;
      while (!shift && guard < 40) begin
         tick();
         guard++;
      end
      repeat (3 * 2 * DV + 1) tick();
      total++;
      if (shift !== 1'b1 || rd_data === '0) begin
         bad++;
         $display("[TB] FAIL midscan_setup: shift %b rd %h want 1 nonzero", shift, rd_data);
      end
      reset_n = 1'b0;
      #1;
      total++;
      if ({sel, capture, shift, update, tck, drck, tdi, busy} !== 8'h00 || rd_data !== '0) begin
         bad++;
         $display("[TB] FAIL midscan_reset: strobes %b rd %h want 0 0",
                  {sel, capture, shift, update, tck, drck, tdi, busy}, rd_data);
      end
      tick();
      reset_n = 1'b1;
      dones = 0;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (done) dones++;
      end
      total++;
      if (dones != 0 || rd_data !== '0) begin
         bad++;
         $display("[TB] FAIL midscan_nodone: dones %0d rd %h want 0 0", dones, rd_data);
      end
      run_single(DW'($urandom), 8'h55, 1'b0);
   endtask

   task automatic test_small();
      int t, r1, r2;
      logic ptck;
      b_wr  = 1'b1;
      b_cap = 1'b0;
      b_start = 1'b1;
      tick();
      b_start = 1'b0;
      t = -1; r1 = -1; r2 = -1;
      ptck = b_tck;
      for (int k = 0; k < 30; k++) begin
         tick();
         if (b_tck && !ptck) begin
            if (r1 < 0) r1 = k + 1;
            else if (r2 < 0) r2 = k + 1;
         end
         ptck = b_tck;
         if (b_done) begin
            t = k + 1;
            break;
         end
      end
      total++;
      if (t != 8) begin
         bad++;
         $display("[TB] FAIL small_done: cycle E0+%0d want E0+9", t + 1);
      end
      total++;
      if (b_rd !== 1'b0 || b_upd !== 1'b1) begin
         bad++;
         $display("[TB] FAIL small_data: rd %b upd %b want 0 1", b_rd, b_upd);
      end
      total++;
      if (r2 - r1 != 2 || r1 != 1) begin
         bad++;
         $display("[TB] FAIL small_period: tck period %0d first rise E0+%0d want 2 E0+2",
                  r2 - r1, r1 + 1);
      end
   endtask

   initial begin
      $display("[TB] starting bscan_scan_master bench");
      test_reset();
      test_single();
      test_ignore_busy();
      test_back_to_back();
      test_reset_midscan();
      test_small();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
